// File: rtl/kernel_window_controller.sv
// 3x3 RGB window generator over two line buffers, one cycle from pixel sample to window.
// Define KWC_FRAME_COUNT_EN to add the out_Frame_Count port.
module kernel_window_controller #(
  parameter int H_MAX     = 2048,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic        in_Pixel_Clk,
  input  logic        Reset,
  input  logic [23:0] in_Data,
  input  logic        in_HSync,
  input  logic        in_VSync,
  input  logic        in_VDE,
  input  logic [3:0]  in_Switch,
  output logic [71:0] out_M1,
  output logic [71:0] out_M2,
  output logic [71:0] out_M3,
  output logic        out_Ready,
  output logic        out_HSync,
  output logic        out_VSync,
  output logic        out_VDE,
  output logic [3:0]  out_Mode,
  output logic        out_Overflow
`ifdef KWC_FRAME_COUNT_EN
  ,
  output logic [15:0] out_Frame_Count
`endif
);

  localparam int CW = (H_MAX > 1) ? $clog2(H_MAX) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_MAX - 1);

  typedef enum logic [1:0] {WAIT_FRAME, LINE, BLANK} state_t;

  state_t        state;
  logic          synced;
  logic          col_full;
  logic [1:0]    row;
  logic [CW-1:0] col;
  logic [23:0]   lb0 [H_MAX];
  logic [23:0]   lb1 [H_MAX];
  logic [23:0]   top;
  logic [23:0]   centre;
  logic          vs_act;
  logic          pix;
  logic          col_ge2;

  assign vs_act  = (in_VSync == VSYNC_POL);
  // after reset nothing is accepted until a VSync has marked a frame boundary
  assign pix     = in_VDE && !vs_act && ((state != WAIT_FRAME) || synced);
  assign top     = lb1[col];
  assign centre  = lb0[col];
  assign col_ge2 = (32'(col) >= 32'd2);

  // col_full marks pixels beyond the buffer width: they still read address H_MAX-1 but never write
  always_ff @(posedge in_Pixel_Clk) begin
    if (pix && !col_full) begin
      lb1[col] <= lb0[col];
      lb0[col] <= in_Data;
    end
  end

  always_ff @(posedge in_Pixel_Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= WAIT_FRAME;
      synced       <= 1'b0;
      row          <= 2'd0;
      col          <= '0;
      col_full     <= 1'b0;
      out_M1       <= '0;
      out_M2       <= '0;
      out_M3       <= '0;
      out_Ready    <= 1'b0;
      out_HSync    <= 1'b0;
      out_VSync    <= 1'b0;
      out_VDE      <= 1'b0;
      out_Mode     <= 4'd0;
      out_Overflow <= 1'b0;
    end else begin
      out_HSync <= in_HSync;
      out_VSync <= in_VSync;
      out_VDE   <= in_VDE;
      out_Ready <= 1'b0;
      if (vs_act) begin
        state        <= WAIT_FRAME;
        synced       <= 1'b1;
        row          <= 2'd0;
        col          <= '0;
        col_full     <= 1'b0;
        out_Overflow <= 1'b0;
        out_Mode     <= in_Switch;
      end else begin
        case (state)
          WAIT_FRAME: if (in_VDE && synced) state <= LINE;
          LINE: begin
            if (!in_VDE) begin
              state    <= BLANK;
              col      <= '0;
              col_full <= 1'b0;
              if (row != 2'd2) row <= row + 2'd1;
            end
          end
          BLANK:   if (in_VDE) state <= LINE;
          default: state <= WAIT_FRAME;
        endcase
        if (pix) begin
          out_M1    <= {top, out_M1[71:24]};
          out_M2    <= {centre, out_M2[71:24]};
          out_M3    <= {in_Data, out_M3[71:24]};
          out_Ready <= (row == 2'd2) && col_ge2;
          if (col_full)              out_Overflow <= 1'b1;
          else if (col == COL_LAST)  col_full     <= 1'b1;
          else                       col          <= col + CW'(1);
        end
      end
    end
  end

`ifdef KWC_FRAME_COUNT_EN
  // out_VSync is the previous cycle's VSync level, so this counts assertion edges only
  always_ff @(posedge in_Pixel_Clk or negedge Reset) begin
    if (!Reset)                                 out_Frame_Count <= 16'd0;
    else if (vs_act && (out_VSync != VSYNC_POL)) out_Frame_Count <= out_Frame_Count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_kernel_window_controller.sv
// Drives two controllers (H_MAX 8 and 4) with shared video and compares against a frame-image model.
module tb_kernel_window_controller;
  localparam int HA = 8;
  localparam int HB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [23:0] data;
  logic        hs, vs, vde;
  logic [3:0]  sw;
  logic [71:0] m1_a, m2_a, m3_a, m1_b, m2_b, m3_b;
  logic        rdy_a, rdy_b, hs_a, hs_b, vs_a, vs_b, vde_a, vde_b, ovf_a, ovf_b;
  logic [3:0]  mode_a, mode_b;
`ifdef KWC_FRAME_COUNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  kernel_window_controller #(.H_MAX(HA), .VSYNC_POL(1'b1)) dut_a (
    .in_Pixel_Clk(clk), .Reset(rst_n), .in_Data(data), .in_HSync(hs), .in_VSync(vs),
    .in_VDE(vde), .in_Switch(sw), .out_M1(m1_a), .out_M2(m2_a), .out_M3(m3_a),
    .out_Ready(rdy_a), .out_HSync(hs_a), .out_VSync(vs_a), .out_VDE(vde_a),
    .out_Mode(mode_a), .out_Overflow(ovf_a)
`ifdef KWC_FRAME_COUNT_EN
    , .out_Frame_Count(fc_a)
`endif
  );

  kernel_window_controller #(.H_MAX(HB), .VSYNC_POL(1'b1)) dut_b (
    .in_Pixel_Clk(clk), .Reset(rst_n), .in_Data(data), .in_HSync(hs), .in_VSync(vs),
    .in_VDE(vde), .in_Switch(sw), .out_M1(m1_b), .out_M2(m2_b), .out_M3(m3_b),
    .out_Ready(rdy_b), .out_HSync(hs_b), .out_VSync(vs_b), .out_VDE(vde_b),
    .out_Mode(mode_b), .out_Overflow(ovf_b)
`ifdef KWC_FRAME_COUNT_EN
    , .out_Frame_Count(fc_b)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: pixels of the current frame, indexed [line][pixel]
  logic [23:0] img [16][16];
  int          row_m, cnt_m, fc_m;
  bit          inl_m, syn_m, vsp_m, hs_m, vs_m, vde_m;
  logic [3:0]  mode_m;
  bit          rdy_m [2];
  bit          ovf_m [2];
  logic [71:0] w1 [2];
  logic [71:0] w2 [2];
  logic [71:0] w3 [2];
  bit [2:0]    kn [2];

  function automatic int hmax(input int i);
    return (i == 0) ? HA : HB;
  endfunction

  task automatic model_reset();
    row_m = 0; cnt_m = 0; fc_m = 0; inl_m = 0; syn_m = 0; vsp_m = 0;
    hs_m = 0; vs_m = 0; vde_m = 0; mode_m = 4'd0;
    for (int i = 0; i < 2; i++) begin
      rdy_m[i] = 0; ovf_m[i] = 0; w1[i] = '0; w2[i] = '0; w3[i] = '0; kn[i] = 3'b111;
    end
  endtask

  task automatic model_step();
    bit vact;
    vact = vs;
    hs_m = hs; vs_m = vs; vde_m = vde;
    if (vact && !vsp_m) fc_m = (fc_m + 1) % 65536;
    vsp_m = vact;
    for (int i = 0; i < 2; i++) rdy_m[i] = 0;
    if (vact) begin
      syn_m = 1; row_m = 0; cnt_m = 0; inl_m = 0; mode_m = sw;
      ovf_m[0] = 0; ovf_m[1] = 0;
    end else if (vde && syn_m) begin
      for (int i = 0; i < 2; i++) begin
        int h, a;
        logic [23:0] top, cen;
        bit k;
        h = hmax(i);
        if (cnt_m < h) begin
          a   = cnt_m;
          k   = (row_m >= 2);
          top = k ? img[row_m-2][cnt_m] : 24'h0;
          cen = (row_m >= 1) ? img[row_m-1][cnt_m] : 24'h0;
        end else begin
          // beyond the buffer: address h-1 already holds this line and the one before
          a   = h - 1;
          k   = (row_m >= 1);
          top = k ? img[row_m-1][h-1] : 24'h0;
          cen = img[row_m][h-1];
          ovf_m[i] = 1;
        end
        w1[i] = {top, w1[i][71:24]};
        w2[i] = {cen, w2[i][71:24]};
        w3[i] = {data, w3[i][71:24]};
        kn[i] = {k, kn[i][2:1]};
        rdy_m[i] = (row_m >= 2) && (a >= 2);
      end
      cnt_m++;
      inl_m = 1;
    end else if (!vde && inl_m) begin
      row_m++; cnt_m = 0; inl_m = 0;
    end
  endtask

  task automatic compare_inst(input string p, input int i, input logic [71:0] m1, input logic [71:0] m2,
                              input logic [71:0] m3, input logic r, input logic hsv, input logic vsv,
                              input logic vdev, input logic ov, input logic [3:0] md);
    check_val({p, "_ready"}, r, rdy_m[i]);
    check_val({p, "_hsync"}, hsv, hs_m);
    check_val({p, "_vsync"}, vsv, vs_m);
    check_val({p, "_vde"}, vdev, vde_m);
    check_val({p, "_ovf"}, ov, ovf_m[i]);
    check_val({p, "_mode"}, md, mode_m);
    if (kn[i] == 3'b111) begin
      check_val({p, "_m1"}, m1, w1[i]);
      check_val({p, "_m2"}, m2, w2[i]);
      check_val({p, "_m3"}, m3, w3[i]);
    end
  endtask

  task automatic compare_all();
    compare_inst("h8", 0, m1_a, m2_a, m3_a, rdy_a, hs_a, vs_a, vde_a, ovf_a, mode_a);
    compare_inst("h4", 1, m1_b, m2_b, m3_b, rdy_b, hs_b, vs_b, vde_b, ovf_b, mode_b);
`ifdef KWC_FRAME_COUNT_EN
    check_val("h8_fcount", fc_a, 72'(fc_m));
    check_val("h4_fcount", fc_b, 72'(fc_m));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input bit h, input bit s, input logic [23:0] d);
    vde = v; hs = h; vs = s; data = d;
    tick();
  endtask

  // hook 1: directed checks for the row*16+col frame; hook 2: overflow onset on the H_MAX=4 unit
  task automatic send_line(input int r, input int w, input bit pat, input int hook);
    for (int c = 0; c < w; c++) begin
      logic [23:0] v;
      v = pat ? 24'(r * 16 + c) : 24'($urandom);
      img[r][c] = v;
      drive(1, 0, 0, v);
      if (hook == 1 && r >= 2 && c < 2) check_val("early_px_ready", rdy_a, 0);
      if (hook == 1 && r == 2 && c == 2) begin
        check_val("first_ready", rdy_a, 1);
        check_val("m2_col1", m2_a[47:24], 24'h000011);
        check_val("m1_col1", m1_a[47:24], 24'h000001);
        check_val("m3_col1", m3_a[47:24], 24'h000021);
      end
      if (hook == 2 && r == 0 && c == 3) check_val("ovf_before", ovf_b, 0);
      if (hook == 2 && r == 0 && c == 4) check_val("ovf_at_px4", ovf_b, 1);
    end
    drive(0, 1, 0, 24'h0);
    drive(0, 0, 0, 24'h0);
    drive(0, 0, 0, 24'h0);
  endtask

  task automatic send_frame(input int hgt, input int w, input bit pat, input int hook);
    drive(0, 0, 1, 24'h0);
    drive(0, 0, 1, 24'h0);
    drive(0, 0, 0, 24'h0);
    drive(0, 0, 0, 24'h0);
    for (int r = 0; r < hgt; r++) begin
      send_line(r, w, pat, hook);
      if (hook == 1 && r == 3) begin
        check_val("blank_ready", rdy_a, 0);
        check_val("blank_m1_held", m1_a[71:48], 24'h000017);
        check_val("blank_m3_held", m3_a[71:48], 24'h000037);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; data = '0; hs = 0; vs = 0; vde = 0; sw = 4'd0;
    model_reset();
    #2;
    compare_all();
    tick();
    tick();
    rst_n = 1'b1;

    // pixels before any VSync must be ignored
    send_line(0, 6, 0, 0);

    sw = 4'b1010;
    send_frame(4, 8, 1, 1);

    send_frame(4, 6, 0, 2);
    drive(0, 0, 1, 24'h0);
    check_val("ovf_cleared", ovf_b, 0);
    drive(0, 0, 0, 24'h0);

    sw = 4'b0011;
    send_frame(2, 5, 0, 0);
    sw = 4'b0001;
    send_line(2, 5, 0, 0);
    check_val("mode_hold", mode_a, 4'b0011);
    drive(0, 0, 1, 24'h0);
    check_val("mode_new", mode_a, 4'b0001);

    send_frame(2, 7, 0, 0);
    for (int c = 0; c < 3; c++) begin
      img[2][c] = 24'($urandom);
      drive(1, 0, 0, img[2][c]);
    end
    rst_n = 1'b0;
    #1;
    check_val("rst_m1", m1_a, 0);
    check_val("rst_m2", m2_a, 0);
    check_val("rst_m3", m3_a, 0);
    check_val("rst_ready", rdy_a, 0);
    check_val("rst_vde", vde_a, 0);
    check_val("rst_mode", mode_a, 0);
    model_reset();
    for (int c = 3; c < 6; c++) drive(1, 0, 0, 24'($urandom));
    rst_n = 1'b1;
    drive(1, 0, 0, 24'h123456);
    drive(0, 0, 0, 24'h0);
    send_line(3, 7, 0, 0);
    send_line(4, 7, 0, 0);
    send_frame(4, 7, 0, 0);

    for (int f = 0; f < 6; f++) begin
      sw = 4'($urandom);
      send_frame($urandom_range(3, 5), $urandom_range(3, 10), 0, 0);
    end
    drive(0, 0, 1, 24'h0);
    drive(0, 0, 0, 24'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
